// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full_adder cell, one bit per clock, LSB first.
// Latency: done pulses WIDTH edges after the accepting start edge; one result per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Co
);
    assign S  = A ^ B ^ Cin;
    assign Co = (A & B) | (Cin & (A ^ B));
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_nxt;

    full_adder u_fa (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Cin (carry_q),
        .S   (fa_s),
        .Co  (fa_co)
    );

    // The result register only needs the WIDTH-1 bits already produced; the
    // bit emerging from the adder this cycle completes the word.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_nxt = fa_s;
        end else begin : g_wn
            logic [WIDTH-2:0] res_sh;
            assign res_nxt = {fa_s, res_sh};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_sh <= '0;
                end else if (state == IDLE && start) begin
                    res_sh <= '0;
                end else if (state == RUN) begin
                    res_sh <= res_nxt[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_co;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= res_nxt;
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against an arithmetic a+b+cin model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_bit_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain; mode 1: start pulses with 0xFF operands mid-run; mode 2: operands churn every cycle
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int mode);
        logic [8:0] exp;
        int lat;
        int extra;
        int r;
        bit got;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        tick();
        chk_eq("w8_busy_after_accept", busy8, 1);
        start8 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 20 && !got) begin
            if (mode == 1) begin
                start8 = (lat == 2 || lat == 6);
                if (start8) begin a8 = 8'hFF; b8 = 8'hFF; end
            end else if (mode == 2) begin
                r = $urandom;
                a8 = r[7:0]; b8 = r[15:8]; cin8 = r[16];
            end
            tick();
            lat++;
            if (done8) got = 1'b1;
        end
        start8 = 1'b0;
        chk_eq("w8_done_seen", got, 1);
        chk_eq("w8_latency", lat, 8);
        chk_eq("w8_result", {cout8, sum8}, exp);
        chk_eq("w8_busy_at_done", busy8, 0);
        tick();
        chk_eq("w8_done_one_cycle", done8, 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8 || busy8) extra++;
        end
        chk_eq("w8_no_extra_activity", extra, 0);
        chk_eq("w8_result_held", {cout8, sum8}, exp);
    endtask

    task automatic op1(input logic a, input logic b, input logic cin);
        logic [1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk_eq("w1_busy_after_accept", busy1, 1);
        tick();
        chk_eq("w1_done_after_one", done1, 1);
        chk_eq("w1_result", {cout1, sum1}, exp);
        tick();
        chk_eq("w1_done_clears", done1, 0);
    endtask

    initial begin
        logic [8:0] expq[$];
        logic [8:0] e_val;
        int last;
        int ndone;
        int extra;
        int r;

        rst_n = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_eq("rst_busy8", busy8, 0);
        chk_eq("rst_done8", done8, 0);
        chk_eq("rst_sum8", sum8, 0);
        chk_eq("rst_cout8", cout8, 0);
        chk_eq("rst_w1_out", {busy1, done1, sum1, cout1}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("idle_no_done", done8, 0);
        end

        op8(8'h00, 8'h00, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'hA5, 8'h5A, 1'b1, 0);
        op8(8'h3C, 8'h41, 1'b0, 0);
        op8(8'h12, 8'h34, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            op8(r[7:0], r[15:8], r[16], 2);
        end

        for (int i = 0; i < 8; i++) begin
            r = i;
            op1(r[2], r[1], r[0]);
        end

        for (int i = 0; i < 12; i++) begin
            r = $urandom;
            op8(r[7:0], r[15:8], r[16], 0);
        end

        // Held start: accepts every 10 edges, operands random on every cycle
        last = -1;
        ndone = 0;
        start8 = 1'b1;
        for (int e = 0; e < 40; e++) begin
            r = $urandom;
            a8 = r[7:0]; b8 = r[15:8]; cin8 = r[16];
            if (e % 10 == 0) expq.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
            tick();
            if (done8) begin
                ndone++;
                e_val = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                chk_eq("held_result", {cout8, sum8}, e_val);
                if (last >= 0) chk_eq("held_spacing", e - last, 10);
                else chk_eq("held_first_latency", e, 8);
                last = e;
            end
        end
        start8 = 1'b0;
        chk_eq("held_done_count", ndone, 4);
        tick();
        tick();

        // Reset in the middle of a run
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_eq("midrun_busy_before", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("midrun_rst_busy", busy8, 0);
        chk_eq("midrun_rst_done", done8, 0);
        chk_eq("midrun_rst_result", {cout8, sum8}, 0);
        tick();
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) extra++;
        end
        chk_eq("midrun_no_done_after", extra, 0);
        op8(8'h80, 8'h80, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
